// File: rtl/lamp_sequence_monitor.sv
// Watches the one-hot lamp bus, checks RED->GREEN->YELLOW order and dwell limits,
// counts completed lamp cycles and latches the first fault until clear_err_i.
module lamp_sequence_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DWELL_W   = 4,
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [2:0]       light_i,
  input  logic             clear_err_i,
  output logic [1:0]       state_out_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             cycle_done_o
);

  typedef enum logic [1:0] {StUnlocked, StLocked, StFault} state_e;

  localparam logic [1:0] ColRed    = 2'd0;
  localparam logic [1:0] ColGreen  = 2'd1;
  localparam logic [1:0] ColYellow = 2'd2;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrCode  = 2'd1;
  localparam logic [1:0] ErrTrans = 2'd2;
  localparam logic [1:0] ErrDwell = 2'd3;

  state_e             state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               cycle_done_q, cycle_done_d;

  logic               code_valid;
  logic [1:0]         code_col;
  logic [1:0]         succ_col;
  logic [DWELL_W:0]   dwell_inc;

  always_comb begin
    code_valid = 1'b1;
    code_col   = ColRed;
    unique case (light_i)
      3'b100:  code_col = ColRed;
      3'b010:  code_col = ColGreen;
      3'b001:  code_col = ColYellow;
      default: code_valid = 1'b0;
    endcase
  end

  assign succ_col  = (col_q == ColYellow) ? ColRed : col_q + 2'd1;
  assign dwell_inc = {1'b0, dwell_q} + 1'b1;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    dwell_d       = dwell_q;
    err_code_d    = err_code_q;
    cycle_count_d = cycle_count_q;
    cycle_done_d  = 1'b0;

    unique case (state_q)
      StUnlocked: begin
        if (!code_valid) begin
          state_d    = StFault;
          err_code_d = ErrCode;
          dwell_d    = '0;
        end else if (code_col == ColRed) begin
          state_d = StLocked;
          col_d   = ColRed;
          dwell_d = DWELL_W'(1);
        end
      end

      StLocked: begin
        if (!code_valid) begin
          state_d    = StFault;
          err_code_d = ErrCode;
          dwell_d    = '0;
        end else if (code_col == col_q) begin
          if (32'(dwell_inc) > MAX_DWELL) begin
            state_d    = StFault;
            err_code_d = ErrDwell;
            dwell_d    = '0;
          end else begin
            dwell_d = dwell_inc[DWELL_W-1:0];
          end
        end else if (code_col == succ_col) begin
          if (32'(dwell_q) < MIN_DWELL) begin
            state_d    = StFault;
            err_code_d = ErrDwell;
            dwell_d    = '0;
          end else begin
            col_d   = succ_col;
            dwell_d = DWELL_W'(1);
            if (col_q == ColYellow) begin
              cycle_count_d = cycle_count_q + 1'b1;
              cycle_done_d  = 1'b1;
            end
          end
        end else begin
          state_d    = StFault;
          err_code_d = ErrTrans;
          dwell_d    = '0;
        end
      end

      StFault: begin
        // Light is ignored here; only clear_err_i leaves the fault.
        if (clear_err_i) begin
          state_d    = StUnlocked;
          err_code_d = ErrNone;
        end
      end

      default: state_d = StUnlocked;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StUnlocked;
      col_q         <= ColRed;
      dwell_q       <= '0;
      err_code_q    <= ErrNone;
      cycle_count_q <= '0;
      cycle_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      dwell_q       <= dwell_d;
      err_code_q    <= err_code_d;
      cycle_count_q <= cycle_count_d;
      cycle_done_q  <= cycle_done_d;
    end
  end

  assign locked_o      = (state_q == StLocked);
  assign err_o         = (state_q == StFault);
  assign state_out_o   = locked_o ? col_q : 2'b11;
  assign err_code_o    = err_code_q;
  assign cycle_count_o = cycle_count_q;
  assign cycle_done_o  = cycle_done_q;

endmodule
